// File: rtl/mem_copy_engine.sv
// Byte-wise memory copy engine: read, capture, write per byte against a synchronous-read RAM.
// Optional running checksum of copied bytes, enabled by defining MEM_COPY_CHECKSUM_EN.
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q, len_q, idx_q;
  logic [ADDR_W-1:0] idx_nxt;
  logic [ADDR_W:0]   idx_inc;
  logic              more;

  assign idx_inc = {1'b0, idx_q} + (ADDR_W+1)'(1);
  assign idx_nxt = idx_inc[ADDR_W-1:0];
  assign more    = idx_inc < {1'b0, len_q};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (len == '0) ? S_DONE : S_RD;
      S_RD:   state_nxt = abort ? S_IDLE : S_CAP;
      S_CAP:  state_nxt = abort ? S_IDLE : S_WR;
      S_WR:   state_nxt = abort ? S_IDLE : (more ? S_RD : S_DONE);
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    mem_write_en = (state == S_WR);
  end

  // mem_addr is preloaded on the edge entering each state so it is valid for that whole state;
  // mem_wdata doubles as the captured data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          src_q    <= src_addr;
          dst_q    <= dst_addr;
          len_q    <= len;
          idx_q    <= '0;
          mem_addr <= src_addr;
        end
        S_CAP: if (!abort) begin
          mem_wdata <= mem_rdata;
          mem_addr  <= dst_q + idx_q;
        end
        S_WR: if (!abort) begin
          idx_q    <= idx_nxt;
          mem_addr <= src_q + idx_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst)                            sum_q <= '0;
    else if (state == S_IDLE && start)  sum_q <= '0;
    else if (state == S_WR)             sum_q <= sum_q + mem_wdata;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized self-checking bench for mem_copy_engine with a synchronous-read RAM model
// and a plain sequential-loop reference for the expected memory image and checksum.
module tb_mem_copy_engine;

`ifdef MEM_COPY_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] src_addr, dst_addr, len;
  logic       busy, done, mem_write_en;
  logic [7:0] checksum, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  int         wr_count;
  int         n_checks = 0;
  int         n_pass   = 0;

  mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .checksum(checksum),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_write_en) begin
      mem[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/busy"}, 32'(busy), 0);
    check({tag, "/done"}, 32'(done), 0);
    check({tag, "/checksum"}, 32'(checksum), 0);
    check({tag, "/write_en"}, 32'(mem_write_en), 0);
    check({tag, "/addr"}, 32'(mem_addr), 0);
    check({tag, "/wdata"}, 32'(mem_wdata), 0);
  endtask

  task automatic preload_rand();
    @(negedge clk);
    for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom);
    #1;
  endtask

  // Expected image: copy one byte at a time in ascending order from a snapshot of memory.
  task automatic ref_copy(input logic [7:0] s, input logic [7:0] d, input int n,
                          output logic [7:0] sum);
    logic [7:0] b;
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = exp_mem[8'(int'(s) + i)];
      exp_mem[8'(int'(d) + i)] = b;
      sum = sum + b;
    end
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    check({tag, "/mem_bad_bytes"}, 32'(bad), 0);
  endtask

  task automatic start_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input logic with_abort);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l;
    start = 1'b1; abort = with_abort;
    wr_count <= 0;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input logic with_abort, input string tag);
    logic [7:0] sum;
    int         e = 0;
    ref_copy(s, d, int'(l), sum);
    start_copy(s, d, l, with_abort);
    while (!done && e < 3 * int'(l) + 8) begin
      @(posedge clk);
      #1;
      e++;
    end
    check({tag, "/done_cycle"}, 32'(e), 32'(3 * int'(l)));
    check({tag, "/checksum"}, 32'(checksum), CK_EN ? 32'(sum) : 0);
    @(posedge clk);
    #1;
    check({tag, "/idle_after_done"}, {30'd0, busy, done}, 0);
    check_mem(tag);
    check({tag, "/writes"}, 32'(wr_count), 32'(l));
  endtask

  initial begin
    logic [7:0] sum, s, d, l;
    int         seen;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    mem_rdata = '0;
    wr_count <= 0;
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Basic four-byte copy
    preload_rand();
    mem[8'h10] <= 8'h01; mem[8'h11] <= 8'h02; mem[8'h12] <= 8'h03; mem[8'h13] <= 8'h04;
    #1;
    run_copy(8'h10, 8'h80, 8'd4, 1'b0, "basic");
    check("basic/dst_word", {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]}, 32'h01020304);

    run_copy(8'h40, 8'h50, 8'd0, 1'b0, "len0");

    // Wrap with overlap across address 0
    preload_rand();
    mem[8'hFE] <= 8'hAA; mem[8'hFF] <= 8'hBB; mem[8'h00] <= 8'hCC; mem[8'h01] <= 8'hDD;
    #1;
    run_copy(8'hFE, 8'h00, 8'd4, 1'b0, "wrap");
    check("wrap/dst_word", {mem[8'h00], mem[8'h01], mem[8'h02], mem[8'h03]}, 32'hAABBAABB);

    preload_rand();
    mem[8'h20] <= 8'h5A;
    #1;
    run_copy(8'h20, 8'h21, 8'd3, 1'b0, "overlap");
    check("overlap/dst", {8'h00, mem[8'h21], mem[8'h22], mem[8'h23]}, 32'h005A5A5A);

    preload_rand();
    run_copy(8'h37, 8'h37, 8'd255, 1'b0, "len255_self");

    for (int k = 0; k < 10; k++) begin
      preload_rand();
      run_copy(8'($urandom), 8'($urandom), 8'($urandom_range(1, 40)),
               1'($urandom), $sformatf("rand%0d", k));
    end

    // Abort in the second byte's CAP: only byte 0 lands
    preload_rand();
    s = 8'h60; d = 8'h90;
    ref_copy(s, d, 1, sum);
    start_copy(s, d, 8'd4, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort/busy", 32'(busy), 0);
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort/no_done", 32'(seen), 0);
    check("abort/writes", 32'(wr_count), 1);
    check_mem("abort");
    run_copy(8'h05, 8'hC0, 8'd6, 1'b1, "after_abort");

    // Start while busy is ignored; reset mid-WR returns outputs to reset values
    preload_rand();
    s = 8'h11; d = 8'hA0; l = 8'd5;
    start_copy(s, d, l, 1'b0);
    @(negedge clk);
    src_addr = 8'h70; dst_addr = 8'hE0; len = 8'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("busy_start/in_wr", 32'(mem_write_en), 1);
    check("busy_start/wr_addr", 32'(mem_addr), 32'(d));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("mid_reset");
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (busy || mem_write_en) seen++;
    end
    check("mid_reset/stays_idle", 32'(seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
